writeback_stage: RTL and testbench

Final pipeline stage of the RV32I core, directly upstream of the register file. Registers the memory-stage result, extracts and sign/zero-extends load data, and selects the writeback source (ALU, load, PC+4). Drives the register file's write port (rd, datawb, regwren) and keeps a 64-bit retired-instruction counter.

---
 rtl/writeback_stage.sv | 126 ++++++++++++
 tb/tb_writeback_stage.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/writeback_stage.sv
// writeback_stage
// Final pipeline stage of the RV32I core, sitting directly in front of the
// register file. It registers the memory-stage result, extracts and extends
// load data, selects the writeback source and drives the register file write
// port. It also keeps a 64-bit retired-instruction counter.
//
// Ports:
//   clk, rst      clock and synchronous active-high reset
//   valid_i       memory stage presents a real instruction
//   stall_i       upstream holds its instruction; a bubble is inserted here
//   flush_i       discard the incoming instruction
//   pc_i          PC of the incoming instruction
//   rd_i          destination register
//   regwren_i     instruction writes rd
//   wbsel_i       00 ALU, 01 load, 10 PC+4, 11 treated as ALU
//   funct3_i      load size/sign (LB, LH, LW, LBU, LHU)
//   alu_res_i     ALU result, or the effective address for loads
//   memdata_i     word-aligned data read from memory
//   valid_o       registered valid of the retiring instruction
//   pc_o          registered PC
//   rd_o          register file write address
//   datawb_o      register file write data
//   regwren_o     register file write enable
//   instret_o     count of retired instructions (wraps modulo 2^64)
module writeback_stage #(
    parameter int DWIDTH = 32,
    parameter int AWIDTH = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_i,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic [AWIDTH-1:0] pc_i,
    input  logic [4:0]        rd_i,
    input  logic              regwren_i,
    input  logic [1:0]        wbsel_i,
    input  logic [2:0]        funct3_i,
    input  logic [DWIDTH-1:0] alu_res_i,
    input  logic [DWIDTH-1:0] memdata_i,
    output logic              valid_o,
    output logic [AWIDTH-1:0] pc_o,
    output logic [4:0]        rd_o,
    output logic [DWIDTH-1:0] datawb_o,
    output logic              regwren_o,
    output logic [63:0]       instret_o
);

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    localparam logic [1:0] WB_LOAD = 2'b01;
    localparam logic [1:0] WB_PC4  = 2'b10;

    logic [7:0]        load_byte;
    logic [15:0]       load_half;
    logic [DWIDTH-1:0] load_data;
    logic [AWIDTH-1:0] pc_plus4;
    logic [DWIDTH-1:0] wb_data;

    // Return address wraps within AWIDTH before being zero-extended.
    assign pc_plus4 = pc_i + AWIDTH'(4);

    // Load lane extraction. Misaligned halfword/word accesses simply drop the
    // low address bits; no trap is raised at this point in the pipeline.
    always_comb begin
        load_byte = 8'h00;
        load_half = 16'h0000;
        load_data = memdata_i;

        case (alu_res_i[1:0])
            2'd0:    load_byte = memdata_i[7:0];
            2'd1:    load_byte = memdata_i[15:8];
            2'd2:    load_byte = memdata_i[23:16];
            default: load_byte = memdata_i[31:24];
        endcase

        load_half = alu_res_i[1] ? memdata_i[31:16] : memdata_i[15:0];

        case (funct3_i)
            F3_LB:   load_data = {{(DWIDTH-8){load_byte[7]}}, load_byte};
            F3_LBU:  load_data = {{(DWIDTH-8){1'b0}}, load_byte};
            F3_LH:   load_data = {{(DWIDTH-16){load_half[15]}}, load_half};
            F3_LHU:  load_data = {{(DWIDTH-16){1'b0}}, load_half};
            default: load_data = memdata_i;
        endcase
    end

    // Writeback source select; the reserved encoding falls back to the ALU.
    always_comb begin
        wb_data = alu_res_i;
        case (wbsel_i)
            WB_LOAD: wb_data = load_data;
            WB_PC4:  wb_data = DWIDTH'(pc_plus4);
            default: wb_data = alu_res_i;
        endcase
    end

    // Pipeline register. Flush and stall both turn into a bubble that clears
    // valid and the write enable while the payload holds, so a held
    // instruction is never retired twice nor written to the register file
    // again. Writes to x0 are suppressed but the instruction still retires.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_o   <= 1'b0;
            regwren_o <= 1'b0;
            rd_o      <= 5'd0;
            pc_o      <= '0;
            datawb_o  <= '0;
            instret_o <= 64'd0;
        end else if (flush_i || stall_i) begin
            valid_o   <= 1'b0;
            regwren_o <= 1'b0;
        end else begin
            valid_o   <= valid_i;
            regwren_o <= valid_i & regwren_i & (rd_i != 5'd0);
            rd_o      <= rd_i;
            pc_o      <= pc_i;
            datawb_o  <= wb_data;
            instret_o <= instret_o + 64'(valid_i);
        end
    end

endmodule

// File: tb/tb_writeback_stage.sv
// tb_writeback_stage
// Self-checking bench for writeback_stage: directed steps from the test plan
// followed by randomized traffic, all compared against a behavioural model
// of the stage and of the downstream register file.
module tb_writeback_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_i;
    logic        stall_i;
    logic        flush_i;
    logic [31:0] pc_i;
    logic [4:0]  rd_i;
    logic        regwren_i;
    logic [1:0]  wbsel_i;
    logic [2:0]  funct3_i;
    logic [31:0] alu_res_i;
    logic [31:0] memdata_i;
    logic        valid_o;
    logic [31:0] pc_o;
    logic [4:0]  rd_o;
    logic [31:0] datawb_o;
    logic        regwren_o;
    logic [63:0] instret_o;

    int checks = 0;
    int errors = 0;

    // Expected state of the stage's outputs
    logic        m_valid;
    logic        m_wren;
    logic [4:0]  m_rd;
    logic [31:0] m_pc;
    logic [31:0] m_data;
    logic [63:0] m_instret;

    // Register file fed by the DUT write port
    logic [31:0] rf [32];

    writeback_stage #(.DWIDTH(32), .AWIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .valid_i   (valid_i),
        .stall_i   (stall_i),
        .flush_i   (flush_i),
        .pc_i      (pc_i),
        .rd_i      (rd_i),
        .regwren_i (regwren_i),
        .wbsel_i   (wbsel_i),
        .funct3_i  (funct3_i),
        .alu_res_i (alu_res_i),
        .memdata_i (memdata_i),
        .valid_o   (valid_o),
        .pc_o      (pc_o),
        .rd_o      (rd_o),
        .datawb_o  (datawb_o),
        .regwren_o (regwren_o),
        .instret_o (instret_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (regwren_o && rd_o != 5'd0) rf[rd_o] <= datawb_o;
    end

    // Writeback value computed arithmetically from the instruction's rules.
    function automatic logic [31:0] refSel(input logic [1:0] ws, input logic [2:0] f3,
                                           input logic [31:0] alu, input logic [31:0] mem,
                                           input logic [31:0] pc);
        logic [31:0] b;
        logic [31:0] h;
        b = (mem >> (8 * (alu % 4))) & 32'hFF;
        h = (mem >> (16 * ((alu / 2) % 2))) & 32'hFFFF;
        if (ws == 2'd2) return pc + 32'd4;
        if (ws != 2'd1) return alu;
        case (f3)
            3'd0:    return (b >= 128) ? b - 32'd256 : b;
            3'd4:    return b;
            3'd1:    return (h >= 32768) ? h - 32'd65536 : h;
            3'd5:    return h;
            default: return mem;
        endcase
    endfunction

    task automatic check1(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput(input string tag);
        check1({tag, ".valid"},   64'(valid_o),   64'(m_valid));
        check1({tag, ".regwren"}, 64'(regwren_o), 64'(m_wren));
        check1({tag, ".rd"},      64'(rd_o),      64'(m_rd));
        check1({tag, ".pc"},      64'(pc_o),      64'(m_pc));
        check1({tag, ".datawb"},  64'(datawb_o),  64'(m_data));
        check1({tag, ".instret"}, instret_o,      m_instret);
    endtask

    // Drives one cycle of inputs, clocks it, and advances the model.
    task automatic applyStimulus(input logic r, input logic f, input logic s, input logic v,
                                 input logic w, input logic [4:0] rd, input logic [1:0] ws,
                                 input logic [2:0] f3, input logic [31:0] pc,
                                 input logic [31:0] alu, input logic [31:0] mem);
        rst = r; flush_i = f; stall_i = s; valid_i = v; regwren_i = w; rd_i = rd;
        wbsel_i = ws; funct3_i = f3; pc_i = pc; alu_res_i = alu; memdata_i = mem;
        @(posedge clk);
        if (r) begin
            m_valid = 0; m_wren = 0; m_rd = 0; m_pc = 0; m_data = 0; m_instret = 0;
        end else if (f || s) begin
            m_valid = 0; m_wren = 0;
        end else begin
            m_valid = v;
            m_wren = v && w && rd != 0;
            m_rd = rd;
            m_pc = pc;
            m_data = refSel(ws, f3, alu, mem, pc);
            if (v) m_instret = m_instret + 64'd1;
        end
        #1;
    endtask

    initial begin
        logic [63:0] cnt_before;
        m_valid = 0; m_wren = 0; m_rd = 0; m_pc = 0; m_data = 0; m_instret = 0;

        // Reset held two cycles with a live instruction on the inputs
        applyStimulus(1, 0, 0, 1, 1, 5'd5, 2'd0, 3'd2, 32'h40, 32'h55, 32'h0);
        applyStimulus(1, 0, 0, 1, 1, 5'd5, 2'd0, 3'd2, 32'h40, 32'h55, 32'h0);
        checkOutput("reset");
        check1("reset.instret0", instret_o, 64'd0);
        check1("reset.wren0", 64'(regwren_o), 64'd0);

        applyStimulus(0, 0, 0, 1, 1, 5'd5, 2'd0, 3'd2, 32'h40, 32'h55, 32'h0);
        checkOutput("first");
        check1("first.valid1", 64'(valid_o), 64'd1);
        check1("first.instret1", instret_o, 64'd1);

        // Load extraction with memdata 0x80FF1234
        applyStimulus(0, 0, 0, 1, 1, 5'd10, 2'd1, 3'd0, 32'h200, 32'h1003, 32'h80FF1234);
        check1("lb", 64'(datawb_o), 64'hFFFFFF80);
        checkOutput("lb");
        applyStimulus(0, 0, 0, 1, 1, 5'd10, 2'd1, 3'd4, 32'h204, 32'h1003, 32'h80FF1234);
        check1("lbu", 64'(datawb_o), 64'h00000080);
        applyStimulus(0, 0, 0, 1, 1, 5'd10, 2'd1, 3'd1, 32'h208, 32'h1002, 32'h80FF1234);
        check1("lh", 64'(datawb_o), 64'hFFFF80FF);
        applyStimulus(0, 0, 0, 1, 1, 5'd10, 2'd1, 3'd5, 32'h20C, 32'h1002, 32'h80FF1234);
        check1("lhu", 64'(datawb_o), 64'h000080FF);
        applyStimulus(0, 0, 0, 1, 1, 5'd10, 2'd1, 3'd1, 32'h210, 32'h1001, 32'h80FF1234);
        check1("lh_mis", 64'(datawb_o), 64'h00001234);
        applyStimulus(0, 0, 0, 1, 1, 5'd10, 2'd1, 3'd2, 32'h214, 32'h1001, 32'h80FF1234);
        check1("lw_mis", 64'(datawb_o), 64'h80FF1234);
        checkOutput("lw_mis");

        // PC+4 wrap, PC+4 normal, reserved select
        applyStimulus(0, 0, 0, 1, 1, 5'd11, 2'd2, 3'd0, 32'hFFFFFFFC, 32'h1, 32'h0);
        check1("pc4_wrap", 64'(datawb_o), 64'h0);
        applyStimulus(0, 0, 0, 1, 1, 5'd11, 2'd2, 3'd0, 32'h100, 32'h1, 32'h0);
        check1("pc4", 64'(datawb_o), 64'h104);
        applyStimulus(0, 0, 0, 1, 1, 5'd11, 2'd3, 3'd0, 32'h104, 32'hDEADBEEF, 32'h0);
        check1("wbsel11", 64'(datawb_o), 64'hDEADBEEF);
        checkOutput("wbsel11");

        // Write to x0 retires without writing
        cnt_before = instret_o;
        applyStimulus(0, 0, 0, 1, 1, 5'd0, 2'd0, 3'd0, 32'h108, 32'h77, 32'h0);
        check1("x0.wren", 64'(regwren_o), 64'd0);
        check1("x0.valid", 64'(valid_o), 64'd1);
        check1("x0.instret", instret_o, cnt_before + 64'd1);

        // Stall, stall+flush and flush alone all bubble with held payload
        applyStimulus(0, 0, 0, 1, 1, 5'd12, 2'd0, 3'd0, 32'h10C, 32'h12345678, 32'h0);
        cnt_before = instret_o;
        applyStimulus(0, 0, 1, 1, 1, 5'd13, 2'd0, 3'd0, 32'h110, 32'hAAAA5555, 32'h0);
        check1("stall.valid", 64'(valid_o), 64'd0);
        check1("stall.wren", 64'(regwren_o), 64'd0);
        check1("stall.data", 64'(datawb_o), 64'h12345678);
        check1("stall.instret", instret_o, cnt_before);
        checkOutput("stall");
        applyStimulus(0, 1, 1, 1, 1, 5'd13, 2'd0, 3'd0, 32'h110, 32'hAAAA5555, 32'h0);
        check1("stflush.data", 64'(datawb_o), 64'h12345678);
        check1("stflush.instret", instret_o, cnt_before);
        checkOutput("stflush");
        applyStimulus(0, 1, 0, 1, 1, 5'd13, 2'd0, 3'd0, 32'h110, 32'hAAAA5555, 32'h0);
        checkOutput("flush");

        // Back-to-back writes after a fresh reset: x3=1, x3=2, x7=3
        applyStimulus(1, 0, 0, 1, 1, 5'd3, 2'd0, 3'd0, 32'h0, 32'h9, 32'h0);
        checkOutput("rst2");
        applyStimulus(0, 0, 0, 1, 1, 5'd3, 2'd0, 3'd0, 32'h0, 32'd1, 32'h0);
        check1("b2b0.data", 64'(datawb_o), 64'd1);
        check1("b2b0.wren", 64'(regwren_o), 64'd1);
        applyStimulus(0, 0, 0, 1, 1, 5'd3, 2'd0, 3'd0, 32'h4, 32'd2, 32'h0);
        check1("b2b1.data", 64'(datawb_o), 64'd2);
        check1("b2b1.wren", 64'(regwren_o), 64'd1);
        applyStimulus(0, 0, 0, 1, 1, 5'd7, 2'd0, 3'd0, 32'h8, 32'd3, 32'h0);
        check1("b2b2.rd", 64'(rd_o), 64'd7);
        check1("b2b2.data", 64'(datawb_o), 64'd3);
        applyStimulus(0, 0, 0, 0, 0, 5'd0, 2'd0, 3'd0, 32'hC, 32'h0, 32'h0);
        check1("rf.x3", 64'(rf[3]), 64'd2);
        check1("rf.x7", 64'(rf[7]), 64'd3);
        check1("b2b.instret", instret_o, 64'd3);

        // Randomized traffic, including occasional mid-stream reset
        for (int i = 0; i < 400; i++) begin
            applyStimulus(($urandom_range(0, 31) == 0), ($urandom_range(0, 7) == 0),
                          ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) != 0),
                          1'($urandom), 5'($urandom), 2'($urandom), 3'($urandom),
                          $urandom, $urandom, $urandom);
            checkOutput("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
